// File: rtl/fifo_sc.sv
// Single-clock parametrised FIFO with fill level, almost-full/almost-empty
// thresholds, normal or show-ahead read mode, synchronous flush and
// registered overflow/underflow pulses.
module fifo_sc #(
  parameter int DWIDTH       = 8,
  parameter int AWIDTH       = 4,
  parameter int SHOWAHEAD    = 0,
  parameter int ALMOST_FULL  = 12,
  parameter int ALMOST_EMPTY = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              srst_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              wrreq_i,
  input  logic              rdreq_i,
  output logic [DWIDTH-1:0] q_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              almost_empty_o,
  output logic              almost_full_o,
  output logic [AWIDTH:0]   usedw_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH + 1)'(DEPTH);
  localparam logic [AWIDTH:0] AF_W    = (AWIDTH + 1)'(ALMOST_FULL);
  localparam logic [AWIDTH:0] AE_W    = (AWIDTH + 1)'(ALMOST_EMPTY);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AWIDTH:0]   wr_ptr;
  logic [AWIDTH:0]   rd_ptr;
  logic [DWIDTH-1:0] mem [DEPTH];
  logic              wr_en;
  logic              rd_en;

  assign usedw_o        = wr_ptr - rd_ptr;
  assign empty_o        = (usedw_o == '0);
  assign full_o         = (usedw_o == DEPTH_W);
  assign almost_full_o  = (usedw_o >= AF_W);
  assign almost_empty_o = (usedw_o <= AE_W);

  // Acceptance uses the flags as they stand before the edge, so a full FIFO
  // still takes a read and an empty one still takes a write.
  assign wr_en = wrreq_i && !full_o;
  assign rd_en = rdreq_i && !empty_o;

  // Storage array; never reset, and a flush suppresses the write.
  always_ff @(posedge clk_i) begin
    if (wr_en && !srst_i) begin
      mem[wr_ptr[AWIDTH-1:0]] <= data_i;
    end
  end

  // Pointer update; flush and reset both return to the empty state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (srst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Error pulses: high for the single cycle after a rejected request.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else if (srst_i) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      overflow_o  <= wrreq_i && full_o;
      underflow_o <= rdreq_i && empty_o;
    end
  end

  if (SHOWAHEAD != 0) begin : g_showahead
    // Head word is presented combinationally; meaningless while empty.
    assign q_o = mem[rd_ptr[AWIDTH-1:0]];
  end else begin : g_normal
    logic [DWIDTH-1:0] q_r;

    // Registered read data, updated only by an accepted read.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        q_r <= '0;
      end else if (srst_i) begin
        q_r <= '0;
      end else if (rd_en) begin
        q_r <= mem[rd_ptr[AWIDTH-1:0]];
      end
    end

    assign q_o = q_r;
  end

endmodule

// File: tb/tb_fifo_sc.sv
// Directed bench for fifo_sc: one normal-mode and one show-ahead instance
// share the same stimulus, so only q_o differs between them.
module tb_fifo_sc;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       srst_i;
  logic [7:0] data_i;
  logic       wrreq_i;
  logic       rdreq_i;

  logic [7:0] q_n, q_s;
  logic       empty_n, full_n, aempty_n, afull_n, ovf_n, unf_n;
  logic       empty_s, full_s, aempty_s, afull_s, ovf_s, unf_s;
  logic [2:0] usedw_n, usedw_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  fifo_sc #(.DWIDTH(8), .AWIDTH(2), .SHOWAHEAD(0), .ALMOST_FULL(3), .ALMOST_EMPTY(1)) dut_n (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .srst_i(srst_i), .data_i(data_i),
    .wrreq_i(wrreq_i), .rdreq_i(rdreq_i), .q_o(q_n), .empty_o(empty_n),
    .full_o(full_n), .almost_empty_o(aempty_n), .almost_full_o(afull_n),
    .usedw_o(usedw_n), .overflow_o(ovf_n), .underflow_o(unf_n)
  );

  fifo_sc #(.DWIDTH(8), .AWIDTH(2), .SHOWAHEAD(1), .ALMOST_FULL(3), .ALMOST_EMPTY(1)) dut_s (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .srst_i(srst_i), .data_i(data_i),
    .wrreq_i(wrreq_i), .rdreq_i(rdreq_i), .q_o(q_s), .empty_o(empty_s),
    .full_o(full_s), .almost_empty_o(aempty_s), .almost_full_o(afull_s),
    .usedw_o(usedw_s), .overflow_o(ovf_s), .underflow_o(unf_s)
  );

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    rst_n_i = 1'b0; srst_i = 1'b0; data_i = 8'h00; wrreq_i = 1'b0; rdreq_i = 1'b0;
    #2;
    n_cmp++; if (empty_n !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b want 1", empty_n); end
    n_cmp++; if (usedw_n !== 3'd0) begin n_bad++; $display("FAIL reset_usedw: got %0d want 0", usedw_n); end
    n_cmp++; if (q_n !== 8'h00) begin n_bad++; $display("FAIL reset_q: got %h want 00", q_n); end
    n_cmp++; if ({aempty_n, full_n, afull_n, ovf_n, unf_n} !== 5'b10000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 10000", {aempty_n, full_n, afull_n, ovf_n, unf_n}); end
    #10 rst_n_i = 1'b1;
    step();
    // mid-stream: two words in, one read out, then asynchronous reset
    wrreq_i = 1'b1; data_i = 8'h3C; step();
    data_i = 8'h4D; step();
    wrreq_i = 1'b0; rdreq_i = 1'b1; step();
    rdreq_i = 1'b0;
    n_cmp++; if (q_n !== 8'h3C) begin n_bad++; $display("FAIL mid_q_before_reset: got %h want 3c", q_n); end
    #3 rst_n_i = 1'b0;
    #1;
    n_cmp++; if (empty_n !== 1'b1 || empty_s !== 1'b1) begin
      n_bad++; $display("FAIL mid_reset_empty: got %b/%b want 1/1", empty_n, empty_s); end
    n_cmp++; if (usedw_n !== 3'd0) begin n_bad++; $display("FAIL mid_reset_usedw: got %0d want 0", usedw_n); end
    n_cmp++; if (q_n !== 8'h00) begin n_bad++; $display("FAIL mid_reset_q: got %h want 00", q_n); end
    #2 rst_n_i = 1'b1;
    step();
  endtask

  task automatic test_fill_overflow;
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      wrreq_i = 1'b1; data_i = vals[i]; step();
      n_cmp++; if (usedw_n !== 3'(i + 1)) begin n_bad++; $display("FAIL fill_usedw[%0d]: got %0d want %0d", i, usedw_n, i + 1); end
      n_cmp++; if (afull_n !== (i + 1 >= 3)) begin n_bad++; $display("FAIL fill_afull[%0d]: got %b want %b", i, afull_n, (i + 1 >= 3)); end
      n_cmp++; if (full_n !== (i + 1 == 4)) begin n_bad++; $display("FAIL fill_full[%0d]: got %b want %b", i, full_n, (i + 1 == 4)); end
      n_cmp++; if (aempty_n !== (i + 1 <= 1)) begin n_bad++; $display("FAIL fill_aempty[%0d]: got %b want %b", i, aempty_n, (i + 1 <= 1)); end
    end
    data_i = 8'h55; step();
    wrreq_i = 1'b0;
    n_cmp++; if (ovf_n !== 1'b1) begin n_bad++; $display("FAIL ovf_pulse: got %b want 1", ovf_n); end
    n_cmp++; if (usedw_n !== 3'd4) begin n_bad++; $display("FAIL ovf_usedw: got %0d want 4", usedw_n); end
    step();
    n_cmp++; if (ovf_n !== 1'b0) begin n_bad++; $display("FAIL ovf_clear: got %b want 0", ovf_n); end
  endtask

  task automatic test_drain_underflow;
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 5; i++) begin
      rdreq_i = 1'b1;
      if (i < 4) begin
        n_cmp++; if (q_s !== vals[i]) begin n_bad++; $display("FAIL sa_head[%0d]: got %h want %h", i, q_s, vals[i]); end
      end
      step();
      n_cmp++; if (q_n !== vals[(i < 4) ? i : 3]) begin
        n_bad++; $display("FAIL drain_q[%0d]: got %h want %h", i, q_n, vals[(i < 4) ? i : 3]); end
      n_cmp++; if (unf_n !== (i == 4)) begin n_bad++; $display("FAIL drain_unf[%0d]: got %b want %b", i, unf_n, (i == 4)); end
    end
    rdreq_i = 1'b0; step();
    n_cmp++; if (unf_n !== 1'b0) begin n_bad++; $display("FAIL unf_clear: got %b want 0", unf_n); end
    n_cmp++; if (empty_n !== 1'b1 || q_n !== 8'h44) begin
      n_bad++; $display("FAIL drain_end: got empty=%b q=%h want empty=1 q=44", empty_n, q_n); end
  endtask

  task automatic test_showahead;
    wrreq_i = 1'b1; data_i = 8'hA5; step();
    wrreq_i = 1'b0;
    n_cmp++; if (q_s !== 8'hA5) begin n_bad++; $display("FAIL sa_write_q: got %h want a5", q_s); end
    n_cmp++; if (empty_s !== 1'b0) begin n_bad++; $display("FAIL sa_write_empty: got %b want 0", empty_s); end
    step();
    n_cmp++; if (q_s !== 8'hA5) begin n_bad++; $display("FAIL sa_hold_q: got %h want a5", q_s); end
    rdreq_i = 1'b1; step();
    rdreq_i = 1'b0;
    n_cmp++; if (empty_s !== 1'b1) begin n_bad++; $display("FAIL sa_read_empty: got %b want 1", empty_s); end
    n_cmp++; if (q_n !== 8'hA5) begin n_bad++; $display("FAIL sa_normal_q: got %h want a5", q_n); end
  endtask

  task automatic test_simultaneous;
    logic [7:0] exp_q;
    for (int i = 0; i < 4; i++) begin
      wrreq_i = 1'b1; data_i = 8'(i + 1); step();
    end
    // full with both requests
    rdreq_i = 1'b1; data_i = 8'h99; step();
    wrreq_i = 1'b0; rdreq_i = 1'b0;
    n_cmp++; if (usedw_n !== 3'd3) begin n_bad++; $display("FAIL full_both_usedw: got %0d want 3", usedw_n); end
    n_cmp++; if (ovf_n !== 1'b1) begin n_bad++; $display("FAIL full_both_ovf: got %b want 1", ovf_n); end
    n_cmp++; if (q_n !== 8'h01) begin n_bad++; $display("FAIL full_both_q: got %h want 01", q_n); end
    rdreq_i = 1'b1;
    for (int i = 0; i < 3; i++) step();
    n_cmp++; if (q_n !== 8'h04 || empty_n !== 1'b1) begin
      n_bad++; $display("FAIL drain_after_full: got q=%h empty=%b want q=04 empty=1", q_n, empty_n); end
    // empty with both requests
    wrreq_i = 1'b1; data_i = 8'h77; step();
    wrreq_i = 1'b0; rdreq_i = 1'b0;
    n_cmp++; if (usedw_n !== 3'd1) begin n_bad++; $display("FAIL empty_both_usedw: got %0d want 1", usedw_n); end
    n_cmp++; if (unf_n !== 1'b1) begin n_bad++; $display("FAIL empty_both_unf: got %b want 1", unf_n); end
    n_cmp++; if (q_n !== 8'h04) begin n_bad++; $display("FAIL empty_both_q: got %h want 04", q_n); end
    wrreq_i = 1'b1; data_i = 8'h78; step();
    // steady state at usedw=2 through several pointer wraps
    rdreq_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      exp_q = (k == 0) ? 8'h77 : (k == 1) ? 8'h78 : 8'(8'h80 + k - 2);
      data_i = 8'(8'h80 + k);
      n_cmp++; if (q_s !== exp_q) begin n_bad++; $display("FAIL stream_sa_q[%0d]: got %h want %h", k, q_s, exp_q); end
      step();
      n_cmp++; if (q_n !== exp_q) begin n_bad++; $display("FAIL stream_q[%0d]: got %h want %h", k, q_n, exp_q); end
      n_cmp++; if (usedw_n !== 3'd2) begin n_bad++; $display("FAIL stream_usedw[%0d]: got %0d want 2", k, usedw_n); end
    end
    wrreq_i = 1'b0; rdreq_i = 1'b0;
  endtask

  task automatic test_flush;
    wrreq_i = 1'b1; data_i = 8'hC3; step();
    n_cmp++; if (usedw_n !== 3'd3) begin n_bad++; $display("FAIL flush_pre_usedw: got %0d want 3", usedw_n); end
    srst_i = 1'b1; data_i = 8'hD4; step();
    srst_i = 1'b0; wrreq_i = 1'b0;
    n_cmp++; if (usedw_n !== 3'd0 || empty_n !== 1'b1) begin
      n_bad++; $display("FAIL flush_state: got usedw=%0d empty=%b want usedw=0 empty=1", usedw_n, empty_n); end
    n_cmp++; if (q_n !== 8'h00) begin n_bad++; $display("FAIL flush_q: got %h want 00", q_n); end
    wrreq_i = 1'b1; data_i = 8'h5A; step();
    wrreq_i = 1'b0; rdreq_i = 1'b1; step();
    rdreq_i = 1'b0;
    n_cmp++; if (q_n !== 8'h5A || empty_n !== 1'b1) begin
      n_bad++; $display("FAIL post_flush: got q=%h empty=%b want q=5a empty=1", q_n, empty_n); end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_showahead();
    test_simultaneous();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
